io_pad_arbiter: RTL and testbench
=================================

// Module: io_pad_arbiter
// PURPOSE
//   Shares one muxable IO pad between TXCOUNT+RXCOUNT function requesters. Drives
//   the pad's func_select directly; grants one function at a time, round-robin.
//   Between owners it parks the pad on a receive function (pin tristated) for
//   TURNAROUND cycles, so two drivers never overlap on the pin.
// PARAMETERS
//   TXCOUNT     2  transmit functions; function indices RXCOUNT..N-1 (higher bits)
//   RXCOUNT     2  receive functions; function indices 0..RXCOUNT-1 (lower bits)
//   PARK_SELECT 0  func_select value while nobody owns the pad; must be < RXCOUNT
//   TURNAROUND  2  park cycles after every release; 0 = no park gap
//   MAX_HOLD    0  max grant length in cycles when others wait; 0 = unlimited
//   localparam N = TXCOUNT+RXCOUNT (N>=2, RXCOUNT>=1), MUXWIDTH = $clog2(N)
// PORTS
//   clk          in   1         system clock, all state on rising edge
//   rst          in   1         asynchronous reset, active-high
//   req          in   N         req[i]: function i wants the pad; level, held while owned
//   gnt          out  N         one-hot or zero; gnt[i]: function i owns the pad
//   func_select  out  MUXWIDTH  to pad's func_select; owner index or PARK_SELECT
//   busy         out  1         1 in GRANT or TURN state
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, gnt=0, func_select=PARK_SELECT, busy=0,
//     rr pointer=0, hold counter=0, turn counter=0. All outputs registered.
//   States: IDLE, GRANT, TURN.
//   IDLE: if |req, winner = first i with req[i], searching ptr, ptr+1, .. mod N.
//     Next cycle: GRANT, gnt=1<<winner, func_select=winner, ptr=(winner+1) mod N.
//     Latency req rise -> gnt: exactly 1 cycle. No req: stay IDLE.
//   GRANT: gnt/func_select stable while req[owner]=1. Other req bits ignored.
//     req[owner] sampled 0 -> next cycle gnt=0, func_select=PARK_SELECT, go TURN
//       (or straight to IDLE if TURNAROUND=0).
//     Minimum grant is 1 cycle: req dropped in first gnt cycle still gets it.
//     MAX_HOLD>0: hold counter counts grant cycles from 1. When counter==MAX_HOLD
//       and any other req bit set -> forced release, same as voluntary release.
//       No competitor -> counter saturates at MAX_HOLD, grant continues; if a
//       competitor then appears, release the following cycle.
//   TURN: gnt=0, func_select=PARK_SELECT for exactly TURNAROUND cycles (counter
//     loaded with TURNAROUND-1, decremented to 0), then IDLE. Requests wait;
//     earliest re-grant is 1 cycle after entering IDLE.
//     Turnaround applies on every release, including RX-to-RX handover.
//   Forced-release owner keeping req high re-enters arbitration as normal; ptr
//     already past it, so others are served first.
//   busy = (state != IDLE).
//   Reset mid-grant or mid-TURN: everything returns to reset values at once,
//     pad parked. Requests still high are arbitrated from ptr=0 after rst falls.
//   Counters sized $clog2(MAX_HOLD+1) / $clog2(TURNAROUND+1), min 1 bit; no wrap.
// TESTING (TXCOUNT=2, RXCOUNT=2, PARK_SELECT=0, TURNAROUND=2, MAX_HOLD=0 unless noted)
//   req=4'b1000 at c0, drop at c5 -> gnt=4'b1000 & sel=3 c1..c5; gnt=0, sel=0 c6..c7;
//     busy=0 from c8.
//   req=4'b1111 held, each owner drops req 1 cycle after gnt -> grant order 0,1,2,3,0;
//     gnt never has 2 bits set; sel=0 for 2 cycles between grants.
//   MAX_HOLD=4: req[2] from c0 held, req[1] from c2 -> gnt[2] c1..c4; park c5..c6;
//     gnt[1] c8. req[2] still high -> granted after req[1] releases.
//   MAX_HOLD=4, only req[3] held 20 cycles -> gnt[3] continuous, never preempted.
//   TURNAROUND=0, req=4'b0011 held with 1-cycle ownership -> no park gap;
//     IDLE 1 cycle between grants.
//   rst pulse while gnt=4'b0100 -> gnt=0, sel=0, busy=0 before the next clk edge;
//     after release with req=4'b0110 -> gnt=4'b0010 first.

Source files
------------

// File: rtl/io_pad_arbiter.sv
// Round-robin owner selection for one muxable IO pad. Between owners the pad is
// parked on a receive function for TURNAROUND cycles so two drivers never meet.
module io_pad_arbiter #(
  parameter int TXCOUNT     = 2,
  parameter int RXCOUNT     = 2,
  parameter int PARK_SELECT = 0,
  parameter int TURNAROUND  = 2,
  parameter int MAX_HOLD    = 0,
  localparam int N          = TXCOUNT + RXCOUNT,
  localparam int MUXWIDTH   = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  output logic [N-1:0]        gnt,
  output logic [MUXWIDTH-1:0] func_select,
  output logic                busy
);

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int TW = (TURNAROUND > 0) ? $clog2(TURNAROUND + 1) : 1;

  localparam logic [MUXWIDTH-1:0] PARK      = MUXWIDTH'(PARK_SELECT);
  localparam logic [HW-1:0]       HOLD_MAX  = HW'(MAX_HOLD);
  localparam logic [HW-1:0]       HOLD_INIT = HW'((MAX_HOLD > 0) ? 1 : 0);
  localparam logic [TW-1:0]       TURN_LOAD = TW'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [N-1:0]        gnt_q, gnt_d;
  logic [MUXWIDTH-1:0] sel_q, sel_d;
  logic                busy_q, busy_d;
  logic [MUXWIDTH-1:0] ptr_q, ptr_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [TW-1:0]       turn_q, turn_d;

  logic                found;
  logic [MUXWIDTH-1:0] winner;
  logic                owner_req;
  logic                others_req;
  logic                release_now;

  // Rotating search starting at ptr_q; the first requester found wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(ptr_q) + i) % N]) begin
        found  = 1'b1;
        winner = MUXWIDTH'((int'(ptr_q) + i) % N);
      end
    end
  end

  always_comb begin
    owner_req   = req[sel_q];
    others_req  = |(req & ~gnt_q);
    release_now = !owner_req ||
                  ((MAX_HOLD > 0) && (hold_q == HOLD_MAX) && others_req);
  end

  // NOTE: every *_d starts from its *_q value so no path leaves a latch behind.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    turn_d  = turn_q;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          gnt_d   = N'(1) << winner;
          sel_d   = winner;
          busy_d  = 1'b1;
          ptr_d   = MUXWIDTH'((int'(winner) + 1) % N);
          hold_d  = HOLD_INIT;
        end
      end

      GRANT: begin
        if (release_now) begin
          gnt_d  = '0;
          sel_d  = PARK;
          hold_d = '0;
          if (TURNAROUND > 0) begin
            state_d = TURN;
            turn_d  = TURN_LOAD;
            busy_d  = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else if ((MAX_HOLD > 0) && (hold_q != HOLD_MAX)) begin
          hold_d = hold_q + 1'b1;
        end
      end

      TURN: begin
        if (turn_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          turn_d = turn_q - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        sel_d   = PARK;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // sees the pre-edge values of all others regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= PARK;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      hold_q  <= '0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
    end
  end

  assign gnt         = gnt_q;
  assign func_select = sel_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_io_pad_arbiter.sv
// Directed bench for io_pad_arbiter: three parameterisations share one clock and
// reset; expected outputs go through a queue and are compared on the falling edge.
module tb_io_pad_arbiter;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [3:0] req_def  = '0;
  logic [3:0] req_hold = '0;
  logic [3:0] req_t0   = '0;

  logic [3:0] gnt_def, gnt_hold, gnt_t0;
  logic [1:0] sel_def, sel_hold, sel_t0;
  logic       busy_def, busy_hold, busy_t0;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  io_pad_arbiter #(
    .TXCOUNT(2), .RXCOUNT(2), .PARK_SELECT(0), .TURNAROUND(2), .MAX_HOLD(0)
  ) u_def (
    .clk(clk), .rst(rst), .req(req_def),
    .gnt(gnt_def), .func_select(sel_def), .busy(busy_def)
  );

  io_pad_arbiter #(
    .TXCOUNT(2), .RXCOUNT(2), .PARK_SELECT(0), .TURNAROUND(2), .MAX_HOLD(4)
  ) u_hold (
    .clk(clk), .rst(rst), .req(req_hold),
    .gnt(gnt_hold), .func_select(sel_hold), .busy(busy_hold)
  );

  io_pad_arbiter #(
    .TXCOUNT(2), .RXCOUNT(2), .PARK_SELECT(0), .TURNAROUND(0), .MAX_HOLD(0)
  ) u_t0 (
    .clk(clk), .rst(rst), .req(req_t0),
    .gnt(gnt_t0), .func_select(sel_t0), .busy(busy_t0)
  );

  task automatic check_pop(input int d, input string tag);
    exp_t e;
    exp_t o;
    e = sb.pop_front();
    case (d)
      0:       o = {gnt_def, sel_def, busy_def};
      1:       o = {gnt_hold, sel_hold, busy_hold};
      default: o = {gnt_t0, sel_t0, busy_t0};
    endcase
    tests_run++;
    assert (o === e) else begin
      tests_failed++;
      $error("FAIL %s (dut %0d): observed gnt=%b sel=%0d busy=%b, expected gnt=%b sel=%0d busy=%b",
             tag, d, o.gnt, o.sel, o.busy, e.gnt, e.sel, e.busy);
    end
  endtask

  // Drive req for the cycle just started, then check that cycle's outputs.
  task automatic cyc(input int d, input logic [3:0] r, input logic [3:0] eg,
                     input logic [1:0] es, input logic eb, input string tag);
    @(posedge clk);
    #1;
    case (d)
      0:       req_def  = r;
      1:       req_hold = r;
      default: req_t0   = r;
    endcase
    sb.push_back({eg, es, eb});
    @(negedge clk);
    check_pop(d, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         o;
    logic [3:0] ob;

    // Reset state on all three instances.
    #3;
    for (int d = 0; d < 3; d++) begin
      sb.push_back({4'b0000, 2'd0, 1'b0});
      check_pop(d, "reset_state");
    end
    #9 rst = 1'b0;

    // Single TX owner: grant c1..c5, park c6..c7, idle from c8.
    cyc(0, 4'b1000, 4'b0000, 2'd0, 1'b0, "t1_c0_idle");
    for (int k = 1; k <= 4; k++) cyc(0, 4'b1000, 4'b1000, 2'd3, 1'b1, "t1_gnt");
    cyc(0, 4'b0000, 4'b1000, 2'd3, 1'b1, "t1_c5_last_gnt");
    cyc(0, 4'b0000, 4'b0000, 2'd0, 1'b1, "t1_c6_park");
    cyc(0, 4'b0000, 4'b0000, 2'd0, 1'b1, "t1_c7_park");
    cyc(0, 4'b0000, 4'b0000, 2'd0, 1'b0, "t1_c8_idle");
    cyc(0, 4'b0000, 4'b0000, 2'd0, 1'b0, "t1_c9_idle");

    // All four request; each owner drops in its second grant cycle -> 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      o  = k % 4;
      ob = 4'b0001 << o;
      cyc(0, 4'b1111,       4'b0000, 2'd0,  1'b0, "rr_idle");
      cyc(0, 4'b1111,       ob,      2'(o), 1'b1, "rr_gnt_first");
      cyc(0, 4'b1111 & ~ob, ob,      2'(o), 1'b1, "rr_gnt_second");
      cyc(0, 4'b1111,       4'b0000, 2'd0,  1'b1, "rr_park1");
      cyc(0, 4'b1111,       4'b0000, 2'd0,  1'b1, "rr_park2");
    end
    cyc(0, 4'b0000, 4'b0000, 2'd0, 1'b0, "rr_end_idle");
    cyc(0, 4'b0000, 4'b0000, 2'd0, 1'b0, "rr_end_idle2");

    // MAX_HOLD=4: req[2] preempted after 4 cycles by req[1], then re-served.
    cyc(1, 4'b0100, 4'b0000, 2'd0, 1'b0, "mh_c0_idle");
    cyc(1, 4'b0100, 4'b0100, 2'd2, 1'b1, "mh_c1_gnt2");
    cyc(1, 4'b0110, 4'b0100, 2'd2, 1'b1, "mh_c2_gnt2");
    cyc(1, 4'b0110, 4'b0100, 2'd2, 1'b1, "mh_c3_gnt2");
    cyc(1, 4'b0110, 4'b0100, 2'd2, 1'b1, "mh_c4_gnt2_last");
    cyc(1, 4'b0110, 4'b0000, 2'd0, 1'b1, "mh_c5_park");
    cyc(1, 4'b0110, 4'b0000, 2'd0, 1'b1, "mh_c6_park");
    cyc(1, 4'b0110, 4'b0000, 2'd0, 1'b0, "mh_c7_idle");
    cyc(1, 4'b0110, 4'b0010, 2'd1, 1'b1, "mh_c8_gnt1");
    cyc(1, 4'b0100, 4'b0010, 2'd1, 1'b1, "mh_c9_gnt1");
    cyc(1, 4'b0100, 4'b0000, 2'd0, 1'b1, "mh_c10_park");
    cyc(1, 4'b0100, 4'b0000, 2'd0, 1'b1, "mh_c11_park");
    cyc(1, 4'b0100, 4'b0000, 2'd0, 1'b0, "mh_c12_idle");
    cyc(1, 4'b0000, 4'b0100, 2'd2, 1'b1, "mh_c13_regnt2");
    cyc(1, 4'b0000, 4'b0000, 2'd0, 1'b1, "mh_c14_park");
    cyc(1, 4'b0000, 4'b0000, 2'd0, 1'b1, "mh_c15_park");
    cyc(1, 4'b0000, 4'b0000, 2'd0, 1'b0, "mh_c16_idle");

    // MAX_HOLD=4, lone requester never preempted; a late competitor forces release.
    cyc(1, 4'b1000, 4'b0000, 2'd0, 1'b0, "sat_c0_idle");
    for (int k = 1; k <= 19; k++) cyc(1, 4'b1000, 4'b1000, 2'd3, 1'b1, "sat_gnt3");
    cyc(1, 4'b1001, 4'b1000, 2'd3, 1'b1, "sat_c20_competitor");
    cyc(1, 4'b1001, 4'b0000, 2'd0, 1'b1, "sat_c21_park");
    cyc(1, 4'b1001, 4'b0000, 2'd0, 1'b1, "sat_c22_park");
    cyc(1, 4'b1001, 4'b0000, 2'd0, 1'b0, "sat_c23_idle");
    cyc(1, 4'b0000, 4'b0001, 2'd0, 1'b1, "sat_c24_gnt0");
    cyc(1, 4'b0000, 4'b0000, 2'd0, 1'b1, "sat_c25_park");
    cyc(1, 4'b0000, 4'b0000, 2'd0, 1'b1, "sat_c26_park");
    cyc(1, 4'b0000, 4'b0000, 2'd0, 1'b0, "sat_c27_idle");

    // TURNAROUND=0: one-cycle ownerships separated by a single IDLE cycle.
    cyc(2, 4'b0011, 4'b0000, 2'd0, 1'b0, "t0_e0_idle");
    cyc(2, 4'b0010, 4'b0001, 2'd0, 1'b1, "t0_e1_gnt0");
    cyc(2, 4'b0011, 4'b0000, 2'd0, 1'b0, "t0_e2_idle");
    cyc(2, 4'b0001, 4'b0010, 2'd1, 1'b1, "t0_e3_gnt1");
    cyc(2, 4'b0011, 4'b0000, 2'd0, 1'b0, "t0_e4_idle");
    cyc(2, 4'b0010, 4'b0001, 2'd0, 1'b1, "t0_e5_gnt0");
    cyc(2, 4'b0000, 4'b0000, 2'd0, 1'b0, "t0_e6_idle");
    cyc(2, 4'b0000, 4'b0000, 2'd0, 1'b0, "t0_e7_idle");

    // Asynchronous reset mid-grant, then arbitration restarts from index 0.
    cyc(0, 4'b0100, 4'b0000, 2'd0, 1'b0, "rst_pre_idle");
    cyc(0, 4'b0100, 4'b0100, 2'd2, 1'b1, "rst_pre_gnt2");
    #2 rst = 1'b1;
    #1;
    sb.push_back({4'b0000, 2'd0, 1'b0});
    check_pop(0, "rst_async_clear");
    req_def = 4'b0110;
    @(negedge clk);
    sb.push_back({4'b0000, 2'd0, 1'b0});
    check_pop(0, "rst_held");
    #1 rst = 1'b0;
    cyc(0, 4'b0110, 4'b0010, 2'd1, 1'b1, "rst_first_gnt1");
    cyc(0, 4'b0000, 4'b0010, 2'd1, 1'b1, "rst_gnt1_hold");
    cyc(0, 4'b0000, 4'b0000, 2'd0, 1'b1, "rst_park");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
